// File: rtl/dbus_arb_pkg.sv
// dbus_arb_pkg: shared types and constants for the data-bus round-robin arbiter.
package dbus_arb_pkg;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int DM_W        = 4;
  localparam int DEF_TIMEOUT = 255;

  // Read data returned to a master whose transfer was aborted by the timeout.
  localparam logic [DATA_W-1:0] ABORT_DATA = 32'hDEADBEEF;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/dbus_rr_pick.sv
// dbus_rr_pick: rotating-priority encoder. The lowest requester at or above i_ptr wins,
// otherwise the scan wraps to the lowest requester overall.
module dbus_rr_pick #(
  parameter int NM = 4,
  parameter int PW = $clog2(NM)
) (
  input  logic [NM-1:0] i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [NM-1:0] o_winner,
  output logic          o_valid
);

  logic [NM-1:0] w_upper;
  logic [NM-1:0] w_cand;

  always_comb begin
    w_upper = '0;
    for (int i = 0; i < NM; i++) begin
      w_upper[i] = i_req[i] && (PW'(i) >= i_ptr);
    end
  end

  // Isolating the lowest set bit of the candidate set gives the one-hot winner.
  assign w_cand   = (|w_upper) ? w_upper : i_req;
  assign o_winner = w_cand & (~w_cand + NM'(1));
  assign o_valid  = |i_req;

endmodule

// File: rtl/dbus_rr_arbiter.sv
// dbus_rr_arbiter: registered round-robin arbiter sharing one data-bus slave among NM masters.
// Define DBUS_ARB_TIMEOUT_EN to abort transfers stalled for TIMEOUT cycles (err pulse, ABORT_DATA).
module dbus_rr_arbiter
  import dbus_arb_pkg::*;
#(
  parameter int NM = 4
`ifdef DBUS_ARB_TIMEOUT_EN
  ,
  parameter int TIMEOUT = DEF_TIMEOUT
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [NM*ADDR_W-1:0] i_addrM,
  input  logic [NM*DATA_W-1:0] i_doutM,
  input  logic [NM-1:0]        i_stbM,
  input  logic [NM-1:0]        i_weM,
  input  logic [NM*DM_W-1:0]   i_dmM,
  output logic [NM*DATA_W-1:0] o_dinM,
  output logic [NM-1:0]        o_nakM,
  output logic [ADDR_W-1:0]    o_addrS,
  output logic [DATA_W-1:0]    o_dinS,
  output logic                 o_stbS,
  output logic                 o_weS,
  output logic [DM_W-1:0]      o_dmS,
  input  logic [DATA_W-1:0]    i_doutS,
  input  logic                 i_nakS,
  output logic [NM-1:0]        o_grant,
  output logic                 o_err
);

  localparam int PW = $clog2(NM);

  arb_state_e    r_state;
  logic [NM-1:0] r_grant;
  logic [PW-1:0] r_ptr;

  logic [NM-1:0] w_pick;
  logic          w_pick_valid;
  logic          w_own_stb;
  logic          w_stbS;
  logic          w_done;
  logic          w_abort;
  logic [PW-1:0] w_gidx;
  logic [PW-1:0] w_ptr_next;

  dbus_rr_pick #(
    .NM(NM),
    .PW(PW)
  ) u_pick (
    .i_req   (i_stbM),
    .i_ptr   (r_ptr),
    .o_winner(w_pick),
    .o_valid (w_pick_valid)
  );

  // AND-OR mux: grant is one-hot in BUSY and zero in IDLE, so the slave sees zeros when idle.
  always_comb begin
    o_addrS = '0;
    o_dinS  = '0;
    o_dmS   = '0;
    o_weS   = 1'b0;
    w_gidx  = '0;
    for (int i = 0; i < NM; i++) begin
      o_addrS = o_addrS | (i_addrM[i*ADDR_W +: ADDR_W] & {ADDR_W{r_grant[i]}});
      o_dinS  = o_dinS  | (i_doutM[i*DATA_W +: DATA_W] & {DATA_W{r_grant[i]}});
      o_dmS   = o_dmS   | (i_dmM[i*DM_W +: DM_W] & {DM_W{r_grant[i]}});
      o_weS   = o_weS   | (i_weM[i] & r_grant[i]);
      w_gidx  = w_gidx  | (PW'(i) & {PW{r_grant[i]}});
    end
  end

  assign w_own_stb  = |(i_stbM & r_grant);
  assign w_stbS     = w_own_stb & ~w_abort;
  assign w_done     = w_stbS & ~i_nakS;
  assign w_ptr_next = (w_gidx == PW'(NM - 1)) ? '0 : w_gidx + PW'(1);

  assign o_stbS  = w_stbS;
  assign o_grant = r_grant;
  assign o_nakM  = i_stbM & ~(r_grant & {NM{~i_nakS | w_abort}});

  always_comb begin
    o_dinM = '0;
    for (int i = 0; i < NM; i++) begin
      o_dinM[i*DATA_W +: DATA_W] = (w_abort && r_grant[i]) ? ABORT_DATA : i_doutS;
    end
  end

  // A dropped strobe while granted frees the bus without moving the pointer, so the
  // same master keeps its turn.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else if (r_state == IDLE) begin
      if (w_pick_valid) begin
        r_grant <= w_pick;
        r_state <= BUSY;
      end
    end else if (w_done || w_abort) begin
      r_ptr   <= w_ptr_next;
      r_grant <= '0;
      r_state <= IDLE;
    end else if (!w_own_stb) begin
      r_grant <= '0;
      r_state <= IDLE;
    end
  end

`ifdef DBUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;

  assign w_abort = (r_state == BUSY) && (r_cnt == CW'(TIMEOUT));
  assign o_err   = w_abort;

  // The counter is held at zero while idle, so every grant starts from a clean count.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (r_state == IDLE) begin
      r_cnt <= '0;
    end else if (i_nakS && !w_abort) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end
`else
  assign w_abort = 1'b0;
  assign o_err   = 1'b0;
`endif

endmodule

// File: tb/tb_dbus_rr_arbiter.sv
// tb_dbus_rr_arbiter: directed scenarios plus random traffic checked every cycle
// against a transaction-level model of the round-robin arbiter.
module tb_dbus_rr_arbiter;

  localparam int NM = 4;
  localparam int TO = 4;
`ifdef DBUS_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [31:0] ABORT_WORD = 32'hDEADBEEF;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [NM*32-1:0] addrM, doutM, dinM;
  logic [NM-1:0]    stbM, weM, nakM, grant;
  logic [NM*4-1:0]  dmM;
  logic [31:0]      addrS, dinS, doutS;
  logic             stbS, weS, nakS, err;
  logic [3:0]       dmS;

  logic [31:0] mAddr[NM];
  logic [31:0] mData[NM];
  logic        mWe[NM];
  logic [3:0]  mDm[NM];
  logic        mStb[NM];

  int               mOwner;
  int               mPtr;
  int               mCnt;
  logic [NM-1:0]    doneMask;
  logic [NM-1:0]    lastNak;
  logic [NM*32-1:0] lastDin;
  logic             lastErr;
  logic             lastStbS;
  int               nakCount;
  int               testsRun = 0;
  int               testsFailed = 0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NM; i++) begin
      addrM[32*i +: 32] = mAddr[i];
      doutM[32*i +: 32] = mData[i];
      dmM[4*i +: 4]     = mDm[i];
      weM[i]            = mWe[i];
      stbM[i]           = mStb[i];
    end
  end

  dbus_rr_arbiter #(
    .NM(NM)
`ifdef DBUS_ARB_TIMEOUT_EN
    ,
    .TIMEOUT(TO)
`endif
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_addrM(addrM),
    .i_doutM(doutM),
    .i_stbM (stbM),
    .i_weM  (weM),
    .i_dmM  (dmM),
    .o_dinM (dinM),
    .o_nakM (nakM),
    .o_addrS(addrS),
    .o_dinS (dinS),
    .o_stbS (stbS),
    .o_weS  (weS),
    .o_dmS  (dmS),
    .i_doutS(doutS),
    .i_nakS (nakS),
    .o_grant(grant),
    .o_err  (err)
  );

  task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
    end
  endtask

  function automatic bit modelAbort();
    return TO_EN && (mOwner >= 0) && (mCnt == TO);
  endfunction

  task automatic compareAll();
    bit               ab;
    logic [NM-1:0]    eGrant;
    logic [NM-1:0]    eNak;
    logic             eStb;
    logic [NM*32-1:0] eDin;
    ab     = modelAbort();
    eGrant = '0;
    eStb   = 1'b0;
    if (mOwner >= 0) begin
      eGrant = NM'(1) << mOwner;
      eStb   = mStb[mOwner] && !ab;
    end
    for (int i = 0; i < NM; i++) begin
      eNak[i]          = mStb[i] && !((i == mOwner) && (ab || !nakS));
      eDin[32*i +: 32] = (ab && i == mOwner) ? ABORT_WORD : doutS;
    end
    checkOutput("grant", 128'(grant), 128'(eGrant));
    checkOutput("stbS", 128'(stbS), 128'(eStb));
    checkOutput("nakM", 128'(nakM), 128'(eNak));
    checkOutput("dinM", 128'(dinM), 128'(eDin));
    checkOutput("err", 128'(err), 128'(ab));
    if (eStb) begin
      checkOutput("addrS", 128'(addrS), 128'(mAddr[mOwner]));
      checkOutput("dinS", 128'(dinS), 128'(mData[mOwner]));
      checkOutput("weS", 128'(weS), 128'(mWe[mOwner]));
      checkOutput("dmS", 128'(dmS), 128'(mDm[mOwner]));
    end
    lastNak  = nakM;
    lastDin  = dinM;
    lastErr  = err;
    lastStbS = stbS;
  endtask

  // One bus cycle of the reference: pick from the rotation when idle, otherwise
  // finish, abort, abandon or keep stalling the current owner.
  task automatic updateModel();
    bit ab;
    ab       = modelAbort();
    doneMask = '0;
    if (mOwner < 0) begin
      for (int k = 0; k < NM; k++) begin
        int j;
        j = (mPtr + k) % NM;
        if (mOwner < 0 && mStb[j]) begin
          mOwner = j;
          mCnt   = 0;
        end
      end
    end else if (ab || (mStb[mOwner] && !nakS)) begin
      doneMask[mOwner] = 1'b1;
      mPtr   = (mOwner + 1) % NM;
      mOwner = -1;
    end else if (!mStb[mOwner]) begin
      mOwner = -1;
    end else if (nakS) begin
      mCnt++;
    end
  endtask

  task automatic applyStimulus();
    #2;
    compareAll();
    @(posedge clk);
    updateModel();
    #1;
  endtask

  task automatic newReq(input int i);
    mStb[i]  = 1'b1;
    mAddr[i] = $urandom;
    mData[i] = $urandom;
    mWe[i]   = 1'($urandom_range(1, 0));
    mDm[i]   = 4'($urandom_range(15, 0));
  endtask

  initial begin
    rst_n    = 1'b0;
    nakS     = 1'b0;
    doutS    = '0;
    doneMask = '0;
    mOwner   = -1;
    mPtr     = 0;
    mCnt     = 0;
    for (int i = 0; i < NM; i++) begin
      mStb[i]  = 1'b0;
      mAddr[i] = '0;
      mData[i] = '0;
      mWe[i]   = 1'b0;
      mDm[i]   = '0;
    end
    mStb[1] = 1'b1;
    @(posedge clk);
    #1;
    compareAll();
    checkOutput("rst_nak_passthru", 128'(nakM), 128'(4'b0010));
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    mStb[1] = 1'b0;

    // Full contention from ptr=0 with a zero-wait slave.
    for (int i = 0; i < NM; i++) newReq(i);
    nakS = 1'b0;
    for (int k = 0; k < 5; k++) begin
      applyStimulus();
      checkOutput("rr_order", 128'(grant), 128'(NM'(1) << (k % NM)));
      applyStimulus();
      for (int i = 0; i < NM; i++) if (doneMask[i]) newReq(i);
    end
    for (int i = 0; i < NM; i++) mStb[i] = 1'b0;
    applyStimulus();

    // Single write from M2.
    newReq(2);
    mAddr[2] = 32'h1000;
    mWe[2]   = 1'b1;
    applyStimulus();
    checkOutput("single_nak_req", 128'(lastNak[2]), 128'(1'b1));
    checkOutput("single_grant", 128'(grant), 128'(4'b0100));
    checkOutput("single_stbS", 128'(stbS), 128'(1'b1));
    checkOutput("single_addrS", 128'(addrS), 128'(32'h1000));
    checkOutput("single_nak_done", 128'(nakM[2]), 128'(1'b0));
    applyStimulus();
    mStb[2] = 1'b0;

    // Pointer wrap from 3 to 0.
    newReq(3);
    newReq(0);
    applyStimulus();
    checkOutput("wrap_first", 128'(grant), 128'(4'b1000));
    applyStimulus();
    mStb[3] = 1'b0;
    applyStimulus();
    checkOutput("wrap_second", 128'(grant), 128'(4'b0001));
    applyStimulus();
    mStb[0] = 1'b0;

    // M1 read with three slave wait states.
    newReq(1);
    mWe[1]   = 1'b0;
    nakS     = 1'b1;
    nakCount = 0;
    applyStimulus();
    nakCount += int'(lastNak[1]);
    repeat (3) begin
      applyStimulus();
      nakCount += int'(lastNak[1]);
    end
    nakS  = 1'b0;
    doutS = 32'h76543210;
    applyStimulus();
    nakCount += int'(lastNak[1]);
    checkOutput("ws_nak_cycles", 128'(nakCount), 128'(4));
    checkOutput("ws_din", 128'(lastDin[63:32]), 128'(32'h76543210));
    mStb[1] = 1'b0;

    // Reset asserted while M0 owns the bus.
    newReq(0);
    nakS = 1'b1;
    applyStimulus();
    checkOutput("mid_grant_before", 128'(grant), 128'(4'b0001));
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_grant", 128'(grant), 128'(4'b0000));
    checkOutput("mid_rst_stbS", 128'(stbS), 128'(1'b0));
    checkOutput("mid_rst_nak", 128'(nakM), 128'(4'b0001));
    mOwner = -1;
    mPtr   = 0;
    mCnt   = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    applyStimulus();
    checkOutput("mid_regrant", 128'(grant), 128'(4'b0001));
    nakS = 1'b0;
    applyStimulus();
    mStb[0] = 1'b0;

    // Granted master drops its strobe: pointer must not move.
    newReq(1);
    newReq(2);
    nakS = 1'b1;
    applyStimulus();
    checkOutput("viol_grant", 128'(grant), 128'(4'b0010));
    mStb[1] = 1'b0;
    applyStimulus();
    newReq(1);
    applyStimulus();
    checkOutput("viol_ptr_kept", 128'(grant), 128'(4'b0010));
    nakS = 1'b0;
    applyStimulus();
    mStb[1] = 1'b0;
    applyStimulus();
    applyStimulus();
    mStb[2] = 1'b0;

`ifdef DBUS_ARB_TIMEOUT_EN
    // Hung slave: abort after TO stall cycles, then M0 is served.
    newReq(3);
    newReq(0);
    nakS = 1'b1;
    applyStimulus();
    checkOutput("to_grant", 128'(grant), 128'(4'b1000));
    repeat (TO) applyStimulus();
    applyStimulus();
    checkOutput("to_err", 128'(lastErr), 128'(1'b1));
    checkOutput("to_din", 128'(lastDin[127:96]), 128'(ABORT_WORD));
    checkOutput("to_nak", 128'(lastNak[3]), 128'(1'b0));
    checkOutput("to_stbS", 128'(lastStbS), 128'(1'b0));
    mStb[3] = 1'b0;
    nakS    = 1'b0;
    applyStimulus();
    checkOutput("to_next_grant", 128'(grant), 128'(4'b0001));
    applyStimulus();
    mStb[0] = 1'b0;
`endif

    // Random traffic; each master holds its request until it completes.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NM; i++) begin
        if (doneMask[i]) begin
          if ($urandom_range(1, 0) == 0) mStb[i] = 1'b0;
          else newReq(i);
        end else if (!mStb[i] && $urandom_range(2, 0) == 0) begin
          newReq(i);
        end
      end
      nakS  = ($urandom_range(2, 0) == 0);
      doutS = $urandom;
      applyStimulus();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
